// File: rtl/sr04_auto_ranger.sv
// Periodic HC-SR04 ranging sequencer with timeout and a 2^AVG_LOG2-deep moving average.
// Optional error counter port: define SR04_RANGER_ERRCNT_EN.
module sr04_auto_ranger #(
  parameter int unsigned PERIOD_CYC  = 6_000_000,
  parameter int unsigned TIMEOUT_CYC = 4_000_000,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned MAX_CM      = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        start_out,
  input  logic [15:0] dist_in,
  input  logic        dist_done_in,
  output logic [15:0] dist_avg,
  output logic        avg_valid,
  output logic        timeout_err,
  output logic        range_err,
`ifdef SR04_RANGER_ERRCNT_EN
  output logic        busy,
  output logic [7:0]  err_count
`else
  output logic        busy
`endif
);

  localparam int unsigned DIST_W = 16;
  localparam int unsigned DEPTH  = 1 << AVG_LOG2;
  localparam int unsigned PCNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned SUM_W  = DIST_W + AVG_LOG2;
  localparam int unsigned WP_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned FILL_W = AVG_LOG2 + 1;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD_CYC - 1);
  // Timeout fires in the cycle the counter's next value reaches TIMEOUT_CYC-1,
  // so the registered timeout_err lands TIMEOUT_CYC cycles after start_out.
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 2);
  localparam logic [DIST_W-1:0] MAX_CM_V  = DIST_W'(MAX_CM);
  localparam logic [WP_W-1:0]   WP_LAST   = WP_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRIG   = 2'd1,
    WAIT   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [PCNT_W-1:0] pcnt;
  logic              period_tick;
  logic [TCNT_W-1:0] tcnt;
  logic              tcnt_hit;

  logic              capture;
  logic              accept;
  logic              reject;
  logic              timeout_set;

  logic [DIST_W-1:0] sample_q;
  logic [DIST_W-1:0] ring_q [DEPTH];
  logic [WP_W-1:0]   wp_q;
  logic [WP_W-1:0]   wp_nxt;
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  sum_nxt;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_inc;
  logic              full_nxt;

  // Free-running measurement period counter, parked at 0 while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (!enable || period_tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  assign period_tick = enable && (pcnt == PCNT_LAST);
  assign tcnt_hit    = (tcnt == TCNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (period_tick) state_nxt = TRIG;
      TRIG:    state_nxt = WAIT;
      WAIT: begin
        if (dist_done_in)  state_nxt = UPDATE;
        else if (tcnt_hit) state_nxt = IDLE;
      end
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State decodes and datapath strobes; a done in the timeout cycle wins
  always_comb begin
    start_out   = 1'b0;
    busy        = 1'b0;
    capture     = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;
    timeout_set = 1'b0;
    case (state)
      TRIG: begin
        start_out = 1'b1;
        busy      = 1'b1;
      end
      WAIT: begin
        busy        = 1'b1;
        capture     = dist_done_in;
        timeout_set = !dist_done_in && tcnt_hit;
      end
      UPDATE: begin
        accept = (sample_q <= MAX_CM_V);
        reject = (sample_q >  MAX_CM_V);
      end
      default: ;
    endcase
  end

  // Timeout counter: cleared in TRIG, counts through WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == TRIG) begin
      tcnt <= '0;
    end else if (state == WAIT) begin
      tcnt <= tcnt + TCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
    end else if (capture) begin
      sample_q <= dist_in;
    end
  end

  assign wp_nxt   = (wp_q == WP_LAST) ? '0 : wp_q + WP_W'(1);
  assign sum_nxt  = sum_q - SUM_W'(ring_q[wp_q]) + SUM_W'(sample_q);
  assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign full_nxt = (fill_inc == FILL_FULL);

  // Ring buffer with running sum; oldest sample is replaced at wp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ring_q[i] <= '0;
      end
      wp_q   <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else if (accept) begin
      ring_q[wp_q] <= sample_q;
      wp_q         <= wp_nxt;
      sum_q        <= sum_nxt;
      fill_q       <= fill_inc;
    end
  end

  // Registered result and error strobes, two cycles after dist_done_in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_avg    <= '0;
      avg_valid   <= 1'b0;
      timeout_err <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      avg_valid   <= accept && full_nxt;
      timeout_err <= timeout_set;
      range_err   <= reject;
      if (accept && full_nxt) begin
        dist_avg <= DIST_W'(sum_nxt >> AVG_LOG2);
      end
    end
  end

`ifdef SR04_RANGER_ERRCNT_EN
  // Saturating count of error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if ((timeout_err || range_err) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sr04_auto_ranger.sv
// Directed bench for sr04_auto_ranger (PERIOD_CYC=1000, TIMEOUT_CYC=600, AVG_LOG2=2, MAX_CM=400).
module tb_sr04_auto_ranger;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        start_out;
  logic [15:0] dist_in;
  logic        dist_done_in;
  logic [15:0] dist_avg;
  logic        avg_valid;
  logic        timeout_err;
  logic        range_err;
  logic        busy;
`ifdef SR04_RANGER_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int prev_s      = 0;

  sr04_auto_ranger #(
    .PERIOD_CYC (1000),
    .TIMEOUT_CYC(600),
    .AVG_LOG2   (2),
    .MAX_CM     (400)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .start_out   (start_out),
    .dist_in     (dist_in),
    .dist_done_in(dist_done_in),
    .dist_avg    (dist_avg),
    .avg_valid   (avg_valid),
    .timeout_err (timeout_err),
    .range_err   (range_err),
`ifdef SR04_RANGER_ERRCNT_EN
    .busy        (busy),
    .err_count   (err_count)
`else
    .busy        (busy)
`endif
  );

  always #5 clk = ~clk;

  // Advance one cycle; observe and drive 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_start(output int s);
    int n = 0;
    while (start_out !== 1'b1 && n < 1200) begin
      step();
      n++;
    end
    chk("start_seen", 32'(start_out), 1);
    s = cyc;
  endtask

  // One measurement: result returned dly cycles after the start pulse
  task automatic meas(input int dly, input logic [15:0] v, input bit exp_valid,
                      input logic [15:0] exp_avg, input bit exp_range, input bit drop_en);
    int s;
    wait_start(s);
    chk("start_period", 32'(s - prev_s), 1000);
    prev_s = s;
    chk("busy_trig", 32'(busy), 1);
    step();
    chk("start_width", 32'(start_out), 0);
    chk("busy_wait", 32'(busy), 1);
    if (drop_en) enable = 1'b0;
    while (cyc < s + dly) step();
    dist_done_in = 1'b1;
    dist_in      = v;
    step();
    dist_done_in = 1'b0;
    dist_in      = '0;
    chk("busy_update", 32'(busy), 0);
    chk("avg_valid_early", 32'(avg_valid), 0);
    chk("timeout_d1", 32'(timeout_err), 0);
    step();
    chk("avg_valid", 32'(avg_valid), 32'(exp_valid));
    chk("dist_avg", 32'(dist_avg), 32'(exp_avg));
    chk("range_err", 32'(range_err), 32'(exp_range));
    chk("timeout_d2", 32'(timeout_err), 0);
    step();
    chk("avg_valid_width", 32'(avg_valid), 0);
    chk("range_err_width", 32'(range_err), 0);
  endtask

  initial begin
    int s;
    int starts;
    rst          = 1'b1;
    enable       = 1'b0;
    dist_in      = '0;
    dist_done_in = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_start", 32'(start_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_avg", 32'(dist_avg), 0);
    chk("rst_valid", 32'(avg_valid), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    chk("rst_rng", 32'(range_err), 0);
`ifdef SR04_RANGER_ERRCNT_EN
    chk("rst_errcnt", 32'(err_count), 0);
`endif

    // Disabled: no starts at all
    rst    = 1'b0;
    starts = 0;
    repeat (1200) begin
      step();
      if (start_out === 1'b1) starts++;
    end
    chk("disabled_no_start", 32'(starts), 0);

    // Enable: first start 1000 cycles later, then averaging fill
    enable = 1'b1;
    prev_s = cyc;
    meas(100, 16'd10, 1'b0, 16'd0,  1'b0, 1'b0);
    meas(100, 16'd20, 1'b0, 16'd0,  1'b0, 1'b0);
    meas(100, 16'd30, 1'b0, 16'd0,  1'b0, 1'b0);
    meas(100, 16'd40, 1'b1, 16'd25, 1'b0, 1'b0);
    meas(100, 16'd50, 1'b1, 16'd35, 1'b0, 1'b0);
    meas(100, 16'd7,  1'b1, 16'd31, 1'b0, 1'b0);

    // Timeout with no result
    wait_start(s);
    chk("tmo_start_period", 32'(s - prev_s), 1000);
    prev_s = s;
    while (cyc < s + 599) step();
    chk("tmo_not_yet", 32'(timeout_err), 0);
    chk("tmo_busy_before", 32'(busy), 1);
    step();
    chk("tmo_pulse", 32'(timeout_err), 1);
    chk("tmo_busy_after", 32'(busy), 0);
    step();
    chk("tmo_width", 32'(timeout_err), 0);

    // Out-of-range rejected, boundary value accepted
    meas(100, 16'd401, 1'b0, 16'd31,  1'b1, 1'b0);
    meas(100, 16'd400, 1'b1, 16'd124, 1'b0, 1'b0);
`ifdef SR04_RANGER_ERRCNT_EN
    chk("errcnt_two", 32'(err_count), 2);
`endif

    // Result in the last timeout cycle beats the timeout
    meas(599, 16'd3, 1'b1, 16'd115, 1'b0, 1'b0);

    // Reset during WAIT with a full window
    wait_start(s);
    chk("rst_start_period", 32'(s - prev_s), 1000);
    repeat (50) step();
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_avg", 32'(dist_avg), 0);
    chk("mid_rst_start", 32'(start_out), 0);
`ifdef SR04_RANGER_ERRCNT_EN
    chk("mid_rst_errcnt", 32'(err_count), 0);
`endif
    step();
    rst    = 1'b0;
    prev_s = cyc;

    // Stray done outside WAIT is ignored
    repeat (5) step();
    dist_done_in = 1'b1;
    dist_in      = 16'd123;
    step();
    dist_done_in = 1'b0;
    dist_in      = '0;
    chk("stray_busy", 32'(busy), 0);
    step();
    chk("stray_valid", 32'(avg_valid), 0);
    chk("stray_rng", 32'(range_err), 0);

    meas(100, 16'd100, 1'b0, 16'd0,   1'b0, 1'b0);
    meas(100, 16'd200, 1'b0, 16'd0,   1'b0, 1'b0);
    meas(100, 16'd300, 1'b0, 16'd0,   1'b0, 1'b0);
    meas(100, 16'd400, 1'b1, 16'd250, 1'b0, 1'b0);

    // Enable drops mid-WAIT: measurement completes, no further starts
    meas(100, 16'd4, 1'b1, 16'd226, 1'b0, 1'b1);
    starts = 0;
    repeat (2500) begin
      step();
      if (start_out === 1'b1) starts++;
    end
    chk("disabled_after_drop", 32'(starts), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
